// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Command, ALU and result signal bundle for alu_op_sequencer.
//                The slave modport is the sequencer's view. The master modport
//                is the view of the command source, ALU and result consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic [CNT_W-1:0] cmd_cnt;

    // ALU connection
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;

    // Result channel
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_carry_any;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_cnt,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry,
        output res_valid, res_data, res_carry, res_carry_any,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_cnt,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry,
        input  res_valid, res_data, res_carry, res_carry_any,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Sequencer around an external 8-bit combinational ALU. It
//                accepts a command, iterates the ALU cmd_cnt+1 times and feeds
//                each result back into operand A. It then presents the last
//                result, its carry and the OR of all carries.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_op_sequencer_if.slave     bus,
    output logic      [WIDTH-1:0] acc,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = 1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry_any;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_carry;
    logic             r_res_carry_any;
    logic             r_res_valid;
    logic             r_cmd_ready;
    logic             r_busy;

    // Control FSM and datapath registers. All outputs come from flops, so the
    // ALU sees stable operands for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_a             <= '0;
            r_b             <= '0;
            r_sel           <= '0;
            r_cnt           <= '0;
            r_carry_any     <= 1'b0;
            r_acc           <= '0;
            r_res_data      <= '0;
            r_res_carry     <= 1'b0;
            r_res_carry_any <= 1'b0;
            r_res_valid     <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_a         <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
                        r_b         <= bus.cmd_b;
                        r_sel       <= bus.cmd_op;
                        r_cnt       <= bus.cmd_cnt;
                        r_carry_any <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc       <= bus.alu_out;
                    r_carry_any <= r_carry_any | bus.alu_carry;
                    if (r_cnt != C_CNT_ZERO) begin
                        // Feed the result back as the next A operand.
                        r_a   <= bus.alu_out;
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end else begin
                        r_res_data      <= bus.alu_out;
                        r_res_carry     <= bus.alu_carry;
                        r_res_carry_any <= r_carry_any | bus.alu_carry;
                        r_res_valid     <= 1'b1;
                        r_state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Hold the result until the consumer takes it. Commands
                    // are not accepted until the cycle after that.
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.alu_a         = r_a;
    assign bus.alu_b         = r_b;
    assign bus.alu_sel       = r_sel;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_data      = r_res_data;
    assign bus.res_carry     = r_res_carry;
    assign bus.res_carry_any = r_res_carry_any;
    assign acc               = r_acc;
    assign busy              = r_busy;

endmodule
`default_nettype wire
